// File: rtl/riscv_lsu_if.sv
// Core-side request/response bundle and data-memory port bundle for riscv_lsu.
// Signal names keep the LSU's point of view (i_ = into the LSU, o_ = out of it).
// The LSU uses core_if.slave and dmem_if.master.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 12
`endif

interface riscv_lsu_core_if #(
  parameter int XLEN = `XLEN
);
  logic            i_lsu_req;
  logic            i_lsu_we;
  logic [2:0]      i_lsu_funct3;
  logic [XLEN-1:0] i_lsu_addr;
  logic [XLEN-1:0] i_lsu_wdata;
  logic            o_lsu_busy;
  logic            o_lsu_done;
  logic [XLEN-1:0] o_lsu_rdata;
  logic            o_lsu_err;

  // pipeline side: issues requests, consumes results
  modport master (
    output i_lsu_req, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
    input  o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_err
  );

  // LSU side
  modport slave (
    input  i_lsu_req, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
    output o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_err
  );
endinterface

interface riscv_lsu_dmem_if #(
  parameter int XLEN          = `XLEN,
  parameter int DMEM_ADDR_BIT = `DMEM_ADDR_BIT
);
  logic [DMEM_ADDR_BIT-3:0] o_dmem_addr;
  logic [XLEN-1:0]          o_dmem_data;
  logic [XLEN/8-1:0]        o_dmem_byte_sel;
  logic                     o_dmem_wr_en;
  logic [XLEN-1:0]          i_dmem_data;

  // LSU side: drives address/strobes, reads combinational data
  modport master (
    output o_dmem_addr, o_dmem_data, o_dmem_byte_sel, o_dmem_wr_en,
    input  i_dmem_data
  );

  // memory side
  modport slave (
    input  o_dmem_addr, o_dmem_data, o_dmem_byte_sel, o_dmem_wr_en,
    output i_dmem_data
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one core request -> one or two data-memory word accesses, lane steering, load extension.
// Latency accept->done: error 1 cycle, aligned 2, split 3; requests are only taken in IDLE (busy otherwise).
// LSU_MISALIGN_EN: when defined, accesses crossing a word boundary split into ACC0+ACC1; otherwise they fail with err.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 12
`endif

module riscv_lsu #(
  parameter int XLEN          = `XLEN,
  parameter int DMEM_ADDR_BIT = `DMEM_ADDR_BIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  riscv_lsu_core_if.slave  core,
  riscv_lsu_dmem_if.master dmem
);

  localparam int WA = DMEM_ADDR_BIT - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
`ifdef LSU_MISALIGN_EN
    ST_ACC1 = 2'd3,
`endif
    ST_DONE = 2'd2
  } state_t;

  // lane mask of an access of the given funct3 size, right-justified
  function automatic logic [3:0] size_mask_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_mask_of = 4'b0001;
      2'd1:    size_mask_of = 4'b0011;
      default: size_mask_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_of = 3'd1;
      2'd1:    size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) is_illegal = (f3 > 3'd2);
    else    is_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // access runs past the end of its word
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    is_split = ({1'b0, off} + size_of(f3)) > 3'd4;
  endfunction

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [DMEM_ADDR_BIT-1:0] addr_q, addr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     err_q, err_d;

  logic [1:0]      off;
  logic [WA-1:0]   word_addr;
  logic [3:0]      lane_lo;
  logic [XLEN-1:0] data_lo;
  logic [XLEN-1:0] rd_lo;
  logic            req_bad;
`ifdef LSU_MISALIGN_EN
  logic [3:0]      lane_hi;
  logic [XLEN-1:0] data_hi;
  logic [XLEN-1:0] rd_hi;
`endif

  logic [WA-1:0]   dmem_addr;
  logic [XLEN-1:0] dmem_data;
  logic [3:0]      dmem_sel;
  logic            dmem_wr;
  logic [XLEN-1:0] rdata_ext;
  logic            done;

  // address bits above the memory size are architecturally ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^core.i_lsu_addr[XLEN-1:DMEM_ADDR_BIT];

  assign off       = addr_q[1:0];
  assign word_addr = addr_q[DMEM_ADDR_BIT-1:2];
  // first word gets the low part of the access shifted up to its byte offset
  assign lane_lo   = size_mask_of(funct3_q) << off;
  assign data_lo   = wdata_q << {off, 3'b000};
  assign rd_lo     = dmem.i_dmem_data >> {off, 3'b000};
`ifdef LSU_MISALIGN_EN
  // second word gets whatever spilled past byte lane 3
  assign lane_hi   = size_mask_of(funct3_q) >> (3'd4 - {1'b0, off});
  assign data_hi   = wdata_q >> (6'd32 - {1'b0, off, 3'b000});
  assign rd_hi     = dmem.i_dmem_data << (6'd32 - {1'b0, off, 3'b000});
  assign req_bad   = is_illegal(core.i_lsu_we, core.i_lsu_funct3);
`else
  assign req_bad   = is_illegal(core.i_lsu_we, core.i_lsu_funct3) ||
                     is_split(core.i_lsu_funct3, core.i_lsu_addr[1:0]);
`endif

  // state and request registers; reset aborts any access in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // next state, request capture, memory port drive and load-data collection
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    result_d  = result_q;
    err_d     = err_q;
    dmem_addr = word_addr;
    dmem_data = data_lo;
    dmem_sel  = 4'b0000;
    dmem_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core.i_lsu_req) begin
          we_d     = core.i_lsu_we;
          funct3_d = core.i_lsu_funct3;
          addr_d   = core.i_lsu_addr[DMEM_ADDR_BIT-1:0];
          wdata_d  = core.i_lsu_wdata;
          result_d = '0;
          err_d    = req_bad;
          state_d  = req_bad ? ST_DONE : ST_ACC0;
        end
      end
      ST_ACC0: begin
        dmem_sel = we_q ? lane_lo : 4'b0000;
        dmem_wr  = we_q;
        if (!we_q) result_d = rd_lo;
`ifdef LSU_MISALIGN_EN
        state_d = is_split(funct3_q, off) ? ST_ACC1 : ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef LSU_MISALIGN_EN
      ST_ACC1: begin
        dmem_addr = word_addr + 1'b1;
        dmem_data = data_hi;
        dmem_sel  = we_q ? lane_hi : 4'b0000;
        dmem_wr   = we_q;
        if (!we_q) result_d = result_q | rd_hi;
        state_d   = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // load result extension by access type; stores and errors carry a zero result
  always_comb begin
    rdata_ext = result_q;
    case (funct3_q)
      3'd0:    rdata_ext = {{24{result_q[7]}}, result_q[7:0]};
      3'd1:    rdata_ext = {{16{result_q[15]}}, result_q[15:0]};
      3'd4:    rdata_ext = {24'd0, result_q[7:0]};
      3'd5:    rdata_ext = {16'd0, result_q[15:0]};
      default: rdata_ext = result_q;
    endcase
  end

  assign done                 = (state_q == ST_DONE);
  assign core.o_lsu_busy      = (state_q != ST_IDLE);
  assign core.o_lsu_done      = done;
  assign core.o_lsu_rdata     = done ? rdata_ext : '0;
  assign core.o_lsu_err       = done & err_q;
  assign dmem.o_dmem_addr     = dmem_addr;
  assign dmem.o_dmem_data     = dmem_data;
  assign dmem.o_dmem_byte_sel = dmem_sel;
  assign dmem.o_dmem_wr_en    = dmem_wr;

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: directed scenarios plus randomized requests against a byte-array memory model.
// Honours LSU_MISALIGN_EN for the expected behaviour of word-crossing accesses.
// Data memory is modelled as a word array with combinational read and byte-lane synchronous write.

module tb_riscv_lsu;

  localparam int XL = 32;
  localparam int AB = 12;
  localparam int NW = 1 << (AB - 2);

  logic clk;
  logic rst;

  riscv_lsu_core_if #(.XLEN(XL)) core_if ();
  riscv_lsu_dmem_if #(.XLEN(XL), .DMEM_ADDR_BIT(AB)) dmem_if ();

  riscv_lsu #(.XLEN(XL), .DMEM_ADDR_BIT(AB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .core  (core_if.slave),
    .dmem  (dmem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem [0:NW-1];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  assign dmem_if.i_dmem_data = mem[dmem_if.o_dmem_addr];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (dmem_if.o_dmem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (dmem_if.o_dmem_byte_sel[b]) mem[dmem_if.o_dmem_addr][8*b +: 8] <= dmem_if.o_dmem_data[8*b +: 8];
    end
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  // observation of one request
  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        any_wr;
  logic [3:0]  tr_sel  [1:8];
  logic [9:0]  tr_addr [1:8];
  logic [31:0] tr_data [1:8];
  logic        tr_wr   [1:8];

  // expectation of one request
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_lat;

  task automatic bd_write(input int w, input logic [31:0] v);
    bd_we   = 1'b1;
    bd_addr = w[9:0];
    bd_data = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
  endtask

  // architectural effect of a request on the byte memory, and its expected result
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat);
    int          size;
    int          off;
    bit          illegal;
    bit          split;
    bit          mis_ok;
    logic [31:0] v;
    logic [11:0] ba;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    off     = int'(a[1:0]);
    split   = (off + size) > 4;
`ifdef LSU_MISALIGN_EN
    mis_ok  = 1'b1;
`else
    mis_ok  = 1'b0;
`endif
    rd = 32'd0;
    er = 1'b0;
    v  = 32'd0;
    if (illegal || (split && !mis_ok)) begin
      er  = 1'b1;
      lat = 1;
    end else begin
      lat = split ? 3 : 2;
      for (int i = 0; i < size; i++) begin
        ba = a[11:0] + 12'(i);
        if (we) ref_mem[ba] = wd[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[ba];
      end
      if (!we) begin
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // drive one request and trace the memory port each cycle until done
  task automatic run_req(input bit skip, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    for (int c = 1; c <= 8; c++) begin
      tr_sel[c] = 4'd0; tr_addr[c] = 10'd0; tr_data[c] = 32'd0; tr_wr[c] = 1'b0;
    end
    if (!skip) @(negedge clk);
    core_if.i_lsu_req    = 1'b1;
    core_if.i_lsu_we     = we;
    core_if.i_lsu_funct3 = f3;
    core_if.i_lsu_addr   = a;
    core_if.i_lsu_wdata  = wd;
    @(posedge clk);
    #1 core_if.i_lsu_req = 1'b0;
    obs_lat = 0; obs_rdata = 32'd0; obs_err = 1'b0; any_wr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tr_sel[c]  = dmem_if.o_dmem_byte_sel;
      tr_addr[c] = dmem_if.o_dmem_addr;
      tr_data[c] = dmem_if.o_dmem_data;
      tr_wr[c]   = dmem_if.o_dmem_wr_en;
      if (dmem_if.o_dmem_wr_en) any_wr = 1'b1;
      if (core_if.o_lsu_done) begin
        obs_lat   = c;
        obs_rdata = core_if.o_lsu_rdata;
        obs_err   = core_if.o_lsu_err;
        break;
      end
    end
  endtask

  task automatic do_op(input bit skip, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    ref_access(we, f3, a, wd, exp_rdata, exp_err, exp_lat);
    run_req(skip, we, f3, a, wd);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    core_if.i_lsu_req = 1'b1; core_if.i_lsu_we = 1'b1; core_if.i_lsu_funct3 = 3'd2;
    core_if.i_lsu_addr = 32'h0000_0010; core_if.i_lsu_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (core_if.o_lsu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", core_if.o_lsu_busy); end
    checks++; if (core_if.o_lsu_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", core_if.o_lsu_done); end
    checks++; if (core_if.o_lsu_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", core_if.o_lsu_rdata); end
    checks++; if (core_if.o_lsu_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", core_if.o_lsu_err); end
    checks++; if (dmem_if.o_dmem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", dmem_if.o_dmem_wr_en); end
    checks++; if (dmem_if.o_dmem_byte_sel !== 4'd0) begin errors++; $display("FAIL rst_sel: got %b expected 0", dmem_if.o_dmem_byte_sel); end
    checks++; if (dmem_if.o_dmem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr: got %h expected 0", dmem_if.o_dmem_addr); end
    checks++; if (dmem_if.o_dmem_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", dmem_if.o_dmem_data); end
    core_if.i_lsu_req = 1'b0;
    rst = 1'b0;
    // store aborted by reset while its ACC0 write strobe is up
    @(negedge clk);
    core_if.i_lsu_req = 1'b1; core_if.i_lsu_we = 1'b1; core_if.i_lsu_funct3 = 3'd2;
    core_if.i_lsu_addr = 32'h0000_0020; core_if.i_lsu_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 core_if.i_lsu_req = 1'b0;
    checks++; if (dmem_if.o_dmem_wr_en !== 1'b1) begin errors++; $display("FAIL acc0_wr_en: got %b expected 1", dmem_if.o_dmem_wr_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dmem_if.o_dmem_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b expected 0", dmem_if.o_dmem_wr_en); end
    checks++; if (core_if.o_lsu_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", core_if.o_lsu_busy); end
    checks++; if (core_if.o_lsu_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", core_if.o_lsu_done); end
    checks++; if (dmem_if.o_dmem_byte_sel !== 4'd0) begin errors++; $display("FAIL abort_sel: got %b expected 0", dmem_if.o_dmem_byte_sel); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (core_if.o_lsu_busy !== 1'b0) begin errors++; $display("FAIL post_abort_idle: got %b expected 0", core_if.o_lsu_busy); end
  endtask

  task automatic test_sw_lw();
    do_op(1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    checks++; if (tr_sel[1] !== 4'b1111) begin errors++; $display("FAIL sw_sel: got %b expected 1111", tr_sel[1]); end
    checks++; if (tr_addr[1] !== 10'd4) begin errors++; $display("FAIL sw_addr: got %0d expected 4", tr_addr[1]); end
    checks++; if (tr_wr[1] !== 1'b1) begin errors++; $display("FAIL sw_wr_en: got %b expected 1", tr_wr[1]); end
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL sw_lat: got %0d expected 2", obs_lat); end
    do_op(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL lw_lat: got %0d expected 2", obs_lat); end
    checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", obs_rdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", obs_err); end
    checks++; if (tr_wr[1] !== 1'b0) begin errors++; $display("FAIL lw_wr_en: got %b expected 0", tr_wr[1]); end
  endtask

  task automatic test_byte();
    do_op(1'b0, 1'b1, 3'd0, 32'h0000_0013, 32'h0000_00A5);
    checks++; if (tr_sel[1] !== 4'b1000) begin errors++; $display("FAIL sb_sel: got %b expected 1000", tr_sel[1]); end
    checks++; if (tr_data[1] !== 32'hA500_0000) begin errors++; $display("FAIL sb_data: got %h expected a5000000", tr_data[1]); end
    do_op(1'b0, 1'b0, 3'd0, 32'h0000_0013, 32'd0);
    checks++; if (obs_rdata !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_rdata: got %h expected ffffffa5", obs_rdata); end
    do_op(1'b0, 1'b0, 3'd4, 32'h0000_0013, 32'd0);
    checks++; if (obs_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000a5", obs_rdata); end
  endtask

  task automatic test_half();
    do_op(1'b0, 1'b1, 3'd1, 32'h0000_0016, 32'h0000_8001);
    checks++; if (tr_sel[1] !== 4'b1100) begin errors++; $display("FAIL sh_sel: got %b expected 1100", tr_sel[1]); end
    checks++; if (tr_data[1] !== 32'h8001_0000) begin errors++; $display("FAIL sh_data: got %h expected 80010000", tr_data[1]); end
    do_op(1'b0, 1'b0, 3'd1, 32'h0000_0016, 32'd0);
    checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", obs_rdata); end
    do_op(1'b0, 1'b0, 3'd5, 32'h0000_0016, 32'd0);
    checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h expected 00008001", obs_rdata); end
  endtask

  task automatic test_misaligned();
    bd_write(3, 32'h1122_3344);
    bd_write(4, 32'h5566_7788);
    do_op(1'b0, 1'b0, 3'd2, 32'h0000_000E, 32'd0);
`ifdef LSU_MISALIGN_EN
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL mis_lat: got %0d expected 3", obs_lat); end
    checks++; if (tr_addr[1] !== 10'd3) begin errors++; $display("FAIL mis_acc0_addr: got %0d expected 3", tr_addr[1]); end
    checks++; if (tr_addr[2] !== 10'd4) begin errors++; $display("FAIL mis_acc1_addr: got %0d expected 4", tr_addr[2]); end
    checks++; if (obs_rdata !== 32'h7788_1122) begin errors++; $display("FAIL mis_rdata: got %h expected 77881122", obs_rdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL mis_err: got %b expected 0", obs_err); end
`else
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL mis_lat: got %0d expected 1", obs_lat); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", obs_err); end
    checks++; if (obs_rdata !== 32'd0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", obs_rdata); end
    checks++; if (any_wr !== 1'b0) begin errors++; $display("FAIL mis_wr_en: got %b expected 0", any_wr); end
`endif
  endtask

  task automatic test_illegal();
    do_op(1'b0, 1'b0, 3'd3, 32'h0000_0010, 32'd0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL ill_ld_err: got %b expected 1", obs_err); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL ill_ld_lat: got %0d expected 1", obs_lat); end
    checks++; if (obs_rdata !== 32'd0) begin errors++; $display("FAIL ill_ld_rdata: got %h expected 0", obs_rdata); end
    checks++; if (any_wr !== 1'b0) begin errors++; $display("FAIL ill_ld_wr_en: got %b expected 0", any_wr); end
    do_op(1'b0, 1'b1, 3'd5, 32'h0000_0010, 32'hFFFF_FFFF);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL ill_st_err: got %b expected 1", obs_err); end
    checks++; if (any_wr !== 1'b0) begin errors++; $display("FAIL ill_st_wr_en: got %b expected 0", any_wr); end
  endtask

  task automatic test_wrap();
    do_op(1'b0, 1'b1, 3'd2, 32'h0000_0FFE, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_EN
    checks++; if (tr_addr[1] !== 10'd1023) begin errors++; $display("FAIL wrap_acc0_addr: got %0d expected 1023", tr_addr[1]); end
    checks++; if (tr_sel[1] !== 4'b1100) begin errors++; $display("FAIL wrap_acc0_sel: got %b expected 1100", tr_sel[1]); end
    checks++; if (tr_addr[2] !== 10'd0) begin errors++; $display("FAIL wrap_acc1_addr: got %0d expected 0", tr_addr[2]); end
    checks++; if (tr_sel[2] !== 4'b0011) begin errors++; $display("FAIL wrap_acc1_sel: got %b expected 0011", tr_sel[2]); end
    checks++; if (tr_data[2][15:0] !== 16'hCAFE) begin errors++; $display("FAIL wrap_acc1_data: got %h expected cafe", tr_data[2][15:0]); end
    do_op(1'b0, 1'b0, 3'd2, 32'h0000_0FFE, 32'd0);
    checks++; if (obs_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_lw: got %h expected cafef00d", obs_rdata); end
`else
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b expected 1", obs_err); end
    checks++; if (any_wr !== 1'b0) begin errors++; $display("FAIL wrap_wr_en: got %b expected 0", any_wr); end
`endif
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 1'b1, 3'd0, 32'h0000_0021, 32'h0000_005A);
    // request raised during DONE must wait for IDLE
    core_if.i_lsu_req = 1'b1; core_if.i_lsu_we = 1'b0; core_if.i_lsu_funct3 = 3'd4;
    core_if.i_lsu_addr = 32'h0000_0021; core_if.i_lsu_wdata = 32'd0;
    @(negedge clk);
    checks++; if (core_if.o_lsu_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b expected 0", core_if.o_lsu_busy); end
    do_op(1'b1, 1'b0, 3'd4, 32'h0000_0021, 32'd0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL b2b_lat: got %0d expected 2", obs_lat); end
    checks++; if (obs_rdata !== 32'h0000_005A) begin errors++; $display("FAIL b2b_rdata: got %h expected 0000005a", obs_rdata); end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    for (int n = 0; n < 120; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      a[11:4] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
      wd = $urandom;
      do_op(1'b0, we, f3, a, wd);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d (we=%b f3=%0d a=%h)", n, obs_lat, exp_lat, we, f3, a); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b (we=%b f3=%0d a=%h)", n, obs_err, exp_err, we, f3, a); end
      checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h (we=%b f3=%0d a=%h)", n, obs_rdata, exp_rdata, we, f3, a); end
    end
  endtask

  task automatic test_memory_image();
    logic [31:0] w_exp;
    for (int w = 0; w < NW; w++) begin
      w_exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      checks++;
      if (mem[w] !== w_exp) begin errors++; $display("FAIL mem_word[%0d]: got %h expected %h", w, mem[w], w_exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = 10'd0; bd_data = 32'd0;
    core_if.i_lsu_req = 1'b0; core_if.i_lsu_we = 1'b0; core_if.i_lsu_funct3 = 3'd0;
    core_if.i_lsu_addr = 32'd0; core_if.i_lsu_wdata = 32'd0;
    for (int w = 0; w < NW; w++) bd_write(w, $urandom);
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_random();
    test_memory_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
